// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS data-memory transaction sequencer.
package mips_mem_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_TIMEOUT   = 255;
    localparam int BYTE_STRIDE   = DEF_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        FINISH
    } state_t;

    function automatic int byte_stride(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mips_beat_counter.sv
// Loadable down-counter with zero flag; counts remaining beats or remaining ack-wait cycles.
module mips_beat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mips_mem_sequencer.sv
// Turns one controller request into a single-beat or BURST_LEN-beat memory transaction.
// Optional feature: define MEM_TIMEOUT_EN to abort (ERR + DONE) after TIMEOUT ack-wait cycles.
module mips_mem_sequencer
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ENABLE,
    input  logic              WRITE,
    input  logic              BURST,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              WREADY,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RDATA,
    output logic              RVALID,
    output logic              ERR,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam int                BEAT_W = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(byte_stride(DATA_W));

    state_t            state;
    logic              ack;
    logic              beat_load;
    logic              beat_dec;
    logic              beat_zero;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_init;
    logic              timeout;

    // Acks are only meaningful while a beat is being requested.
    assign ack       = (state == ACCESS) && MEM_ACK;
    assign beat_load = (state == IDLE) && ENABLE;
    assign beat_init = BURST ? BEAT_W'(BURST_LEN - 1) : '0;
    assign beat_dec  = ack && (beat_cnt != '0);

    mips_beat_counter #(.W(BEAT_W)) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (beat_load),
        .load_val (beat_init),
        .dec      (beat_dec),
        .count    (beat_cnt),
        .zero     (beat_zero)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_zero;
    logic              waiting;

    // Loaded with TIMEOUT-1 so that zero flags the TIMEOUT-th consecutive wait cycle.
    assign waiting = (state == ACCESS) && !MEM_ACK;
    assign timeout = waiting && wait_zero;

    mips_beat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (beat_load || ack),
        .load_val (WAIT_W'(TIMEOUT - 1)),
        .dec      (waiting && (wait_cnt != '0)),
        .count    (wait_cnt),
        .zero     (wait_zero)
    );
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    assign WREADY    = MEM_ACK && MEM_WE;
    assign MEM_WDATA = WDATA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            RVALID   <= 1'b0;
            ERR      <= 1'b0;
            MEM_REQ  <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_ADDR <= '0;
            RDATA    <= '0;
        end else begin
            // NOTE: pulse outputs default low every cycle so each assertion lasts exactly one clock.
            DONE   <= 1'b0;
            RVALID <= 1'b0;
            ERR    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ENABLE) begin
                        state    <= ACCESS;
                        BUSY     <= 1'b1;
                        MEM_REQ  <= 1'b1;
                        MEM_WE   <= WRITE;
                        MEM_ADDR <= ADDR;
                    end
                end
                ACCESS: begin
                    if (MEM_ACK) begin
                        if (!MEM_WE) begin
                            RDATA  <= MEM_RDATA;
                            RVALID <= 1'b1;
                        end
                        if (beat_zero) begin
                            state   <= FINISH;
                            DONE    <= 1'b1;
                            MEM_REQ <= 1'b0;
                            MEM_WE  <= 1'b0;
                        end else begin
                            MEM_ADDR <= MEM_ADDR + STRIDE;
                        end
                    end else if (timeout) begin
                        state   <= FINISH;
                        DONE    <= 1'b1;
                        ERR     <= 1'b1;
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Scoreboard bench for mips_mem_sequencer: driver queues expected beats, a memory responder
// models wait states, and a monitor compares every beat, read return and completion.
module tb_mips_mem_sequencer;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 8;
    localparam int IDLE_MAX  = 500;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ENABLE = 1'b0;
    logic              WRITE = 1'b0;
    logic              BURST = 1'b0;
    logic [ADDR_W-1:0] ADDR = '0;
    logic [DATA_W-1:0] WDATA = '0;
    logic              WREADY;
    logic              BUSY;
    logic              DONE;
    logic [DATA_W-1:0] RDATA;
    logic              RVALID;
    logic              ERR;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_ACK = 1'b0;
    logic [DATA_W-1:0] MEM_RDATA = '0;

    always #5 clk = ~clk;

    mips_mem_sequencer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ENABLE    (ENABLE),
        .WRITE     (WRITE),
        .BURST     (BURST),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .WREADY    (WREADY),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RDATA     (RDATA),
        .RVALID    (RVALID),
        .ERR       (ERR),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_ACK   (MEM_ACK),
        .MEM_RDATA (MEM_RDATA)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } beat_t;

    typedef struct {
        int   busy;
        logic err;
    } done_t;

    beat_t             exp_beat_q[$];
    logic [DATA_W-1:0] exp_rdata_q[$];
    done_t             exp_done_q[$];
    int                wait_q[$];
    logic [DATA_W-1:0] mem_rdata_q[$];
    logic [DATA_W-1:0] wdata_src_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    int cur_wait    = 0;
    bit have_beat   = 1'b0;
    bit last_wr_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beat i of a transaction targets start + i*stride (mod 2^32); each beat
    // costs its wait cycles plus one ack cycle, and one more cycle is spent on completion.
    task automatic issue_txn(input logic wr, input logic bst, input logic [ADDR_W-1:0] addr,
                             input int waits, input logic [DATA_W-1:0] rd0, input bit tmo);
        int      n;
        int      busy;
        int      w;
        beat_t   b;
        logic [DATA_W-1:0] d;
        @(negedge clk);
        n    = bst ? BURST_LEN : 1;
        busy = 1;
        for (int i = 0; i < n; i++) begin
            w       = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
            busy   += w + 1;
            b.addr  = addr + 32'(i * (DATA_W / 8));
            b.we    = wr;
            b.wdata = $urandom;
            exp_beat_q.push_back(b);
            wait_q.push_back(w);
            if (wr) begin
                if (i == 0) WDATA = b.wdata;
                else        wdata_src_q.push_back(b.wdata);
            end else if (!tmo) begin
                d = (i == 0) ? rd0 : $urandom;
                mem_rdata_q.push_back(d);
                exp_rdata_q.push_back(d);
            end
        end
        if (tmo) exp_done_q.push_back('{TIMEOUT + 1, 1'b1});
        else     exp_done_q.push_back('{busy, 1'b0});
        ENABLE = 1'b1;
        WRITE  = wr;
        BURST  = bst;
        ADDR   = addr;
        @(posedge clk);
        #1;
        check("busy_rise", BUSY, 1);
        check("req_rise", MEM_REQ, 1);
        ENABLE = 1'b0;
        WRITE  = $urandom;
        BURST  = $urandom;
        ADDR   = $urandom;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (BUSY && c < IDLE_MAX) begin
            @(negedge clk);
            c++;
        end
        check("idle_within_bound", (c < IDLE_MAX), 1);
        check("beats_left", exp_beat_q.size(), 0);
        check("rdata_left", exp_rdata_q.size(), 0);
        check("done_left", exp_done_q.size(), 0);
    endtask

    // Memory responder: acts just after each rising edge so the monitor sees a settled cycle.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            MEM_ACK = 1'b0;
        end else begin
            if (last_wr_ack) WDATA = (wdata_src_q.size() > 0) ? wdata_src_q.pop_front() : $urandom;
            last_wr_ack = 1'b0;
            MEM_ACK     = 1'b0;
            MEM_RDATA   = $urandom;
            if (MEM_REQ) begin
                if (!have_beat && wait_q.size() > 0) begin
                    cur_wait  = wait_q.pop_front();
                    have_beat = 1'b1;
                end
                if (have_beat) begin
                    if (cur_wait == 0) begin
                        MEM_ACK   = 1'b1;
                        have_beat = 1'b0;
                        if (MEM_WE) last_wr_ack = 1'b1;
                        else if (mem_rdata_q.size() > 0) MEM_RDATA = mem_rdata_q.pop_front();
                    end else begin
                        cur_wait--;
                    end
                end
            end else begin
                MEM_ACK = ($urandom_range(0, 3) == 0);
            end
        end
    end

    int                busy_cnt  = 0;
    bit                prev_done = 1'b0;
    beat_t             mon_beat;
    done_t             mon_done;
    logic [DATA_W-1:0] mon_rd;

    always @(negedge clk) begin
        if (!mon_en) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("busy_fall_with_done", BUSY, 0);
            if (BUSY) busy_cnt++;
            else      busy_cnt = 0;
            if (MEM_REQ) begin
                if (exp_beat_q.size() == 0) begin
                    check("spurious_req", MEM_REQ, 0);
                end else begin
                    mon_beat = exp_beat_q[0];
                    check("mem_addr", MEM_ADDR, mon_beat.addr);
                    check("mem_we", MEM_WE, mon_beat.we);
                    if (MEM_ACK) begin
                        void'(exp_beat_q.pop_front());
                        check("wready", WREADY, mon_beat.we);
                        if (mon_beat.we) check("mem_wdata", MEM_WDATA, mon_beat.wdata);
                    end else begin
                        check("wready_wait", WREADY, 0);
                    end
                end
            end else if (MEM_ACK) begin
                check("wready_stray_ack", WREADY, 0);
            end
            if (RVALID) begin
                if (exp_rdata_q.size() == 0) begin
                    check("spurious_rvalid", RVALID, 0);
                end else begin
                    mon_rd = exp_rdata_q.pop_front();
                    check("rdata", RDATA, mon_rd);
                end
            end
            if (DONE) begin
                if (exp_done_q.size() == 0) begin
                    check("spurious_done", DONE, 0);
                end else begin
                    mon_done = exp_done_q.pop_front();
                    check("busy_cycles", busy_cnt, mon_done.busy);
                    check("err_at_done", ERR, mon_done.err);
                    if (mon_done.err) exp_beat_q.delete();
                    else check("last_rvalid_with_done", exp_rdata_q.size(), 0);
                end
            end else if (ERR) begin
                check("err_stray", ERR, 0);
            end
            prev_done = DONE;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_err", ERR, 0);
        check("rst_mem_req", MEM_REQ, 0);
        check("rst_mem_we", MEM_WE, 0);
        check("rst_wready", WREADY, 0);
        check("rst_mem_addr", MEM_ADDR, 0);
        check("rst_rdata", RDATA, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single read, zero-wait ack.
        issue_txn(1'b0, 1'b0, 32'h0000_0100, 0, 32'hDEAD_BEEF, 1'b0);
        wait_idle();
        check("single_addr_hold", MEM_ADDR, 32'h0000_0100);

        // Burst write, ack every cycle.
        issue_txn(1'b1, 1'b1, 32'h0000_0200, 0, 32'h0, 1'b0);
        wait_idle();
        check("burst_addr_hold", MEM_ADDR, 32'h0000_020C);

        // Burst read with two wait cycles before every beat.
        issue_txn(1'b0, 1'b1, 32'h0000_0600, 2, $urandom, 1'b0);
        wait_idle();

        // Address wrap past all-ones.
        issue_txn(1'b0, 1'b1, 32'hFFFF_FFF8, 0, $urandom, 1'b0);
        wait_idle();
        check("wrap_addr_hold", MEM_ADDR, 32'h0000_0004);

        // Request while busy is dropped.
        issue_txn(1'b1, 1'b1, 32'h0000_0500, 1, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        ENABLE = 1'b1;
        WRITE  = 1'b0;
        BURST  = 1'b0;
        ADDR   = 32'h0000_0999;
        @(negedge clk);
        ENABLE = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("ignored_enable_idle", BUSY, 0);

        // Asynchronous reset in the middle of a waiting access.
        issue_txn(1'b0, 1'b1, 32'h0000_0300, 3, $urandom, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check("arst_busy", BUSY, 0);
        check("arst_mem_req", MEM_REQ, 0);
        check("arst_mem_we", MEM_WE, 0);
        check("arst_mem_addr", MEM_ADDR, 0);
        check("arst_rdata", RDATA, 0);
        check("arst_rvalid", RVALID, 0);
        check("arst_done", DONE, 0);
        exp_beat_q.delete();
        exp_rdata_q.delete();
        exp_done_q.delete();
        wait_q.delete();
        mem_rdata_q.delete();
        wdata_src_q.delete();
        have_beat   = 1'b0;
        last_wr_ack = 1'b0;
        MEM_ACK     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        issue_txn(1'b1, 1'b0, 32'h0000_0400, 0, 32'h0, 1'b0);
        wait_idle();

        // Randomized mix of reads/writes, singles/bursts, wait states and near-wrap addresses.
        for (int t = 0; t < 40; t++) begin
            logic [ADDR_W-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            issue_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, -1, $urandom, 1'b0);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef MEM_TIMEOUT_EN
        // Memory never acknowledges: abort after TIMEOUT wait cycles.
        issue_txn(1'b0, 1'b0, 32'h0000_0700, 100000, 32'h0, 1'b1);
        wait_idle();
        have_beat = 1'b0;
        wait_q.delete();
        check("timeout_busy_low", BUSY, 0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mem_sequencer.md
# mips_mem_sequencer

Memory-transaction sequencer sitting between the MIPS controller (BURST/ENABLE/WRITE/BUSY decode of load/store opcodes) and the data-memory port. It turns one request into a single-beat or fixed-length burst of memory accesses. It drives address, write strobe and request toward memory, and waits for a per-beat acknowledge. While a transaction is in flight it reports BUSY back to the controller, and it pulses DONE on completion.

## Interface
- ADDR_W, 32, address width (byte address)
- DATA_W, 32, data width
- BURST_LEN, 4, beats per burst transaction (≥2)
- TIMEOUT, 255, ack-wait limit in cycles (used only with MEM_TIMEOUT_EN)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ENABLE  in  1  request strobe from controller
- WRITE  in  1  1 = store, 0 = load; sampled with ENABLE
- BURST  in  1  1 = BURST_LEN beats, 0 = one beat; sampled with ENABLE
- ADDR  in  ADDR_W  start address; sampled with ENABLE
- WDATA  in  DATA_W  write data for the current beat
- WREADY  out  1  current write beat consumed; requester advances WDATA
- BUSY  out  1  transaction in progress
- DONE  out  1  one-cycle completion pulse
- RDATA  out  DATA_W  read data, registered
- RVALID  out  1  one-cycle pulse per read beat
- ERR  out  1  timeout abort pulse (MEM_TIMEOUT_EN only, else tied 0)
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  memory write enable
- MEM_ADDR  out  ADDR_W  memory address
- MEM_WDATA  out  DATA_W  memory write data (combinational pass of WDATA)
- MEM_ACK  in  1  beat accepted/completed by memory
- MEM_RDATA  in  DATA_W  read data, valid with MEM_ACK

## Operation
- States: IDLE, ACCESS, FINISH.
- IDLE: ENABLE=1 at a clock edge latches WRITE, BURST and ADDR. The beat counter is loaded with BURST ? BURST_LEN-1 : 0. The block moves to ACCESS.
- ACCESS: MEM_REQ=1, MEM_WE=latched WRITE, MEM_ADDR=current address.
  - On MEM_ACK with the counter ≠ 0: address += DATA_W/8, counter decrements, and the block stays in ACCESS.
  - On MEM_ACK with the counter = 0: the block goes to FINISH.
- FINISH: DONE=1 for one cycle, then IDLE.
- Read beat: on MEM_ACK, RDATA←MEM_RDATA and RVALID pulses on the next cycle.
- Write beat: WREADY = MEM_ACK & MEM_WE (combinational).
- Address arithmetic is modulo 2^ADDR_W; wrap past all-ones to 0 is silent.
- ENABLE while BUSY=1 is ignored, not queued. ENABLE in FINISH is also ignored.
- MEM_ACK outside ACCESS is ignored.
- Outputs RDATA/MEM_ADDR hold their last value when idle.

## Timing
- Reset values: state IDLE; BUSY, DONE, RVALID, ERR, MEM_REQ, MEM_WE, WREADY=0; MEM_ADDR, RDATA=0; counter 0.
- Reset is asynchronous: asserting rst_n mid-transaction forces the reset values immediately. The in-flight beat is dropped.
- ENABLE sampled at edge N → MEM_REQ and BUSY high from edge N.
- BUSY stays high through ACCESS and FINISH. It falls in the same cycle DONE falls.
- A single-beat access with zero-wait ACK (ACK in the first ACCESS cycle) takes:
  - 1 ACCESS cycle, then DONE in the next cycle.
  - ENABLE-to-DONE latency is 2 cycles.
- A full burst with zero-wait ACK takes BURST_LEN ACCESS cycles plus 1 FINISH cycle.
- Each wait cycle (MEM_REQ=1, MEM_ACK=0) extends ACCESS by exactly one cycle. Address, WE and the counter are held stable during waits.
- RVALID lags its MEM_ACK by one cycle. The final RVALID coincides with DONE.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A wait counter resets on each MEM_ACK and on entry to ACCESS, and increments on every ACCESS cycle without MEM_ACK.
  - On reaching TIMEOUT, ERR pulses one cycle, MEM_REQ drops, and the FSM goes to FINISH. DONE still pulses, so BUSY always terminates.
- MEM_TIMEOUT_EN undefined:
  - No wait counter exists and ERR is constant 0.
  - ACCESS waits on MEM_ACK indefinitely.

## Structure
- Shared package mips_mem_pkg:
  - State enum (IDLE/ACCESS/FINISH).
  - Default BURST_LEN, DATA_W and TIMEOUT constants.
  - Byte-stride constant (DATA_W/8).
- One sub-module, mips_beat_counter:
  - Loadable down-counter with a zero flag.
  - Instantiated for beat count, and a second time for the timeout wait under MEM_TIMEOUT_EN.

## Test plan
- Single read:
  - Stimulus: ENABLE=1, WRITE=0, BURST=0, ADDR=0x100; memory ACKs immediately with 0xDEADBEEF.
  - Response: MEM_ADDR=0x100 for one cycle; RVALID with RDATA=0xDEADBEEF; DONE 2 cycles after ENABLE.
- Burst write:
  - Stimulus: BURST=1, WRITE=1, ADDR=0x200; ACK every cycle.
  - Response: MEM_ADDR 0x200, 0x204, 0x208, 0x20C; 4 WREADY pulses; DONE on cycle 5.
- Wait states:
  - Stimulus: burst read with MEM_ACK low 2 cycles before each beat.
  - Response: address holds during waits; 4 RVALIDs; BUSY high 13 cycles.
- Address wrap:
  - Stimulus: burst at ADDR=0xFFFFFFF8.
  - Response: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Ignored request and reset:
  - Stimulus: ENABLE pulsed mid-burst; then rst_n low during ACCESS.
  - Response: the mid-burst ENABLE has no effect; on reset, all outputs 0 immediately and the next ENABLE starts cleanly.
- MEM_TIMEOUT_EN, TIMEOUT=8:
  - Stimulus: MEM_ACK never asserted.
  - Response: ERR and DONE pulse after 8 wait cycles; BUSY drops.
